// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  localparam int unsigned ADDR_W_DEF  = 12;
  localparam int unsigned INSTR_W_DEF = 19;

  localparam logic [INSTR_W_DEF-1:0] NOP = '0;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM with registered read; storage is not reset.
module imem_ram #(
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned INSTR_W = 19
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [INSTR_W-1:0] wdata,
  output logic [INSTR_W-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]   idx;

  // Only the bits needed to span DEPTH index the array.
  assign idx = IDX_W'(addr);

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/prog_instruction_memory.sv
// Loadable instruction memory: post-reset clear, streaming program load and
// registered ready/valid fetch, all sharing one single-port RAM.
module prog_instruction_memory
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned INSTR_W        = INSTR_W_DEF,
  parameter int unsigned DEPTH          = 4096,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic               addr_err,
  input  logic               load_start,
  input  logic [ADDR_W-1:0]  load_base,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam imem_state_t       RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  imem_state_t        state, state_nxt;
  logic [ADDR_W-1:0]  clr_ptr, wr_ptr;
  logic               fetch_acc_c, oob_c;
  logic [31:0]        base_mod_c;
  logic               ram_we_c;
  logic [ADDR_W-1:0]  ram_addr_c;
  logic [INSTR_W-1:0] ram_wdata_c, rdata;
  logic               fetch_pend, pend_oob;

  assign base_mod_c = 32'(load_base) % 32'(DEPTH);
  assign oob_c      = 32'(fetch_addr) >= 32'(DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RST_STATE;
    else      state <= state_nxt;
  end

  // Next state plus the RAM port mux: clear, load or fetch owns the port.
  always_comb begin
    state_nxt   = state;
    ram_we_c    = 1'b0;
    ram_addr_c  = fetch_addr;
    ram_wdata_c = load_data;
    fetch_acc_c = 1'b0;
    case (state)
      CLEAR: begin
        ram_we_c    = 1'b1;
        ram_addr_c  = clr_ptr;
        ram_wdata_c = INSTR_W'(NOP);
        if (clr_ptr == LAST_ADDR) state_nxt = IDLE;
      end
      IDLE: begin
        if (load_start) state_nxt = LOAD;
        else            fetch_acc_c = fetch_req;
      end
      LOAD: begin
        ram_addr_c = wr_ptr;
        ram_we_c   = load_valid;
        if (load_valid && load_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_ptr     <= '0;
      wr_ptr      <= '0;
      fetch_pend  <= 1'b0;
      pend_oob    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      addr_err    <= 1'b0;
      fetch_ready <= ~CLEAR_ON_RESET;
      load_ready  <= 1'b0;
      busy        <= CLEAR_ON_RESET;
    end else begin
      if (state == CLEAR)
        clr_ptr <= (clr_ptr == LAST_ADDR) ? '0 : clr_ptr + ADDR_W'(1);
      if (state == IDLE && load_start)
        wr_ptr <= ADDR_W'(base_mod_c);
      else if (state == LOAD && load_valid)
        wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_W'(1);
      // Read data arrives one edge after acceptance; instr registers it on the next.
      fetch_pend  <= fetch_acc_c;
      pend_oob    <= fetch_acc_c & oob_c;
      instr_valid <= fetch_pend;
      if (fetch_pend) begin
        instr    <= pend_oob ? INSTR_W'(NOP) : rdata;
        addr_err <= pend_oob;
      end
      fetch_ready <= (state_nxt == IDLE);
      load_ready  <= (state_nxt == LOAD);
      busy        <= (state_nxt != IDLE);
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_c),
    .addr (ram_addr_c),
    .wdata(ram_wdata_c),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_prog_instruction_memory.sv
// Self-checking bench for prog_instruction_memory (DEPTH=16, clear on reset).
module tb_prog_instruction_memory;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned INSTR_W = 19;
  localparam int unsigned DEPTH   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               fetch_req, fetch_ready, instr_valid, addr_err;
  logic [ADDR_W-1:0]  fetch_addr, load_base;
  logic [INSTR_W-1:0] instr, load_data;
  logic               load_start, load_valid, load_last, load_ready, busy;

  int vec  = 0;
  int errs = 0;

  logic [INSTR_W-1:0] model [DEPTH];
  logic [INSTR_W-1:0] prog [17] = '{
    19'h0A001, 19'h0A102, 19'h11203, 19'h2C004, 19'h3D105, 19'h40216,
    19'h51307, 19'h62008, 19'h7F109, 19'h0B20A, 19'h1C30B, 19'h2D00C,
    19'h3E10D, 19'h4F20E, 19'h5030F, 19'h66010, 19'h7FFFF
  };
  int                 fq[$];
  logic [INSTR_W-1:0] dq[$];

  prog_instruction_memory #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr(instr), .addr_err(addr_err),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] exp_instr(input int a);
    return (a >= int'(DEPTH)) ? '0 : model[a];
  endfunction

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
  endtask

  task automatic check_reset_vals();
    chk("rst_fetch_ready", fetch_ready, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_busy", busy, 1);
  endtask

  // Count edges until busy drops; bounded so a stuck clear still ends.
  task automatic wait_clear();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 64);
    chk("clear_cycles", n, DEPTH);
    chk("post_clear_fetch_ready", fetch_ready, 1);
  endtask

  // Back-to-back fetches of fq; result for fetch k is checked after edge k+1.
  task automatic fetch_burst();
    int n = fq.size();
    chk("fetch_ready_pre", fetch_ready, 1);
    for (int i = 0; i <= n + 1; i++) begin
      @(negedge clk);
      load_start = 1'b0;
      if (i < n) begin
        fetch_req  = 1'b1;
        fetch_addr = ADDR_W'(fq[i]);
      end else begin
        fetch_req  = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 1 && i - 1 < n) begin
        chk($sformatf("valid@%0d", fq[i-1]), instr_valid, 1);
        chk($sformatf("instr@%0d", fq[i-1]), instr, exp_instr(fq[i-1]));
        chk($sformatf("addr_err@%0d", fq[i-1]), addr_err, (fq[i-1] >= int'(DEPTH)));
      end else if (i == n + 1) begin
        chk("valid_drop", instr_valid, 0);
      end
    end
    fq.delete();
  endtask

  // Load dq at base with random stalls and ignored fetch/start attempts.
  // abort_at >= 0 returns (still in LOAD) before that word is written.
  task automatic load_burst(input int base, input bit contend, input int abort_at);
    int n = dq.size();
    @(negedge clk);
    load_start = 1'b1;
    load_base  = ADDR_W'(base);
    if (contend) begin
      fetch_req  = 1'b1;
      fetch_addr = ADDR_W'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    chk("start_load_ready", load_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_fetch_ready", fetch_ready, 0);
    for (int i = 0; i < n; i++) begin
      int gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        load_valid = 1'b0;
        load_start = 1'($urandom_range(0, 1));
        load_base  = ADDR_W'($urandom_range(0, 15));
        fetch_req  = 1'($urandom_range(0, 1));
        fetch_addr = ADDR_W'($urandom_range(0, 15));
        @(posedge clk); #1;
        chk("gap_load_ready", load_ready, 1);
        chk("gap_fetch_ready", fetch_ready, 0);
        chk("gap_instr_valid", instr_valid, 0);
      end
      if (i == abort_at) return;
      @(negedge clk);
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data  = dq[i];
      load_last  = (i == n - 1);
      fetch_req  = 1'($urandom_range(0, 1));
      fetch_addr = ADDR_W'($urandom_range(0, 15));
      @(posedge clk); #1;
      model[(base + i) % int'(DEPTH)] = dq[i];
      if (i == n - 1) begin
        chk("end_load_ready", load_ready, 0);
        chk("end_fetch_ready", fetch_ready, 1);
        chk("end_busy", busy, 0);
      end else begin
        chk("word_load_ready", load_ready, 1);
        chk("word_instr_valid", instr_valid, 0);
      end
    end
    @(negedge clk);
    idle_inputs();
    dq.delete();
  endtask

  initial begin
    idle_inputs();
    fetch_addr = '0;
    load_base  = '0;
    load_data  = '0;

    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    @(negedge clk) rst = 1'b1;
    wait_clear();
    model_clear();
    for (int a = 0; a < int'(DEPTH); a++) fq.push_back(a);
    fetch_burst();

    // Program load at base 1; 17 words into 16 entries wraps onto address 1.
    for (int i = 0; i < 17; i++) dq.push_back(prog[i]);
    load_burst(1, 1'b0, -1);
    for (int a = 1; a <= 17; a++) fq.push_back(a);
    fetch_burst();

    // Wrap-around from 14.
    for (int i = 0; i < 4; i++) dq.push_back(INSTR_W'($urandom));
    load_burst(14, 1'b0, -1);
    fq = '{14, 15, 0, 1};
    fetch_burst();

    // Out-of-range then in-range.
    fq = '{20, 3, 20, 31, 15};
    fetch_burst();

    for (int i = 0; i < 24; i++) fq.push_back($urandom_range(0, 31));
    fetch_burst();

    // Contention: load_start and fetch_req together.
    for (int i = 0; i < 5; i++) dq.push_back(INSTR_W'($urandom));
    load_burst($urandom_range(0, 15), 1'b1, -1);
    for (int a = 0; a < int'(DEPTH); a++) fq.push_back(a);
    fetch_burst();

    // Reset after 3 of 8 words.
    for (int i = 0; i < 8; i++) dq.push_back(INSTR_W'($urandom) | 19'h1);
    load_burst(5, 1'b0, 3);
    dq.delete();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1 check_reset_vals();
    model_clear();
    @(negedge clk) rst = 1'b1;
    wait_clear();
    fq = '{5, 6, 7};
    for (int a = 0; a < int'(DEPTH); a++) fq.push_back(a);
    fetch_burst();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
